// File: rtl/ldl_cdc_bus_stream.sv
// rtl/ldl_cdc_bus_stream.sv - turns atomic CDC bus word updates into a buffered valid/ready stream
module ldl_cdc_bus_stream #(
    parameter int                 WIDTH   = 8,
    parameter int                 DEPTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    parameter int                 CW      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      ovf,
    output logic [CW-1:0]             ovf_cnt,
    input  logic                      ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_DIFF = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] din_q;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    logic evt;
    logic full;
    logic empty;
    logic pop;
    logic push_ok;
    logic drop;

    // Change detection against the last word seen; identical repeats are invisible by design.
    always_comb begin
        evt     = (din_q != last_q);
        empty   = (wr_ptr == rd_ptr);
        full    = ((wr_ptr ^ rd_ptr) == FULL_DIFF);
        pop     = !empty && out_ready;
        // A pop in the same cycle frees the slot for a push into a full FIFO.
        push_ok = evt && (!full || pop);
        drop    = evt && full && !pop;
    end

    // Sample the CDC bus and remember the last word turned into an event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_q  <= RST_VAL;
            last_q <= RST_VAL;
        end else begin
            din_q <= din;
            if (evt) begin
                last_q <= din_q;
            end
        end
    end

    // FIFO storage; stale entries are never visible because out_data is gated by empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din_q;
        end
    end

    // Read/write pointers with a wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop outranks a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_clr) begin
                ovf_cnt <= CW'(1);
            end else if (!(&ovf_cnt)) begin
                ovf_cnt <= ovf_cnt + CW'(1);
            end
        end else if (ovf_clr) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end
    end

    // Outputs derive only from registered state, so out_ready never reaches them combinationally.
    always_comb begin
        out_valid = !empty;
        out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
        level     = wr_ptr - rd_ptr;
    end

endmodule

// File: tb/tb_ldl_cdc_bus_stream.sv
// tb/tb_ldl_cdc_bus_stream.sv - scoreboard bench for ldl_cdc_bus_stream against a queue model
module tb_ldl_cdc_bus_stream;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       level;
    logic             ovf;
    logic [CW-1:0]    ovf_cnt;
    logic             ovf_clr;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    // model state: pipeline register, last detected word, FIFO contents, overflow
    logic [WIDTH-1:0] m_dq   = '0;
    logic [WIDTH-1:0] m_last = '0;
    logic [WIDTH-1:0] mq [$];
    logic [WIDTH-1:0] sb [$];
    bit               m_ovf = 0;
    int               m_cnt = 0;

    ldl_cdc_bus_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(8'h00), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .ovf       (ovf),
        .ovf_cnt   (ovf_cnt),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: one edge of the spec's rules applied to queues.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_dq   = '0;
            m_last = '0;
            mq.delete();
            sb.delete();
            m_ovf  = 0;
            m_cnt  = 0;
        end else begin
            bit did_pop;
            bit dropped;
            did_pop = (mq.size() > 0) && out_ready;
            dropped = 0;
            if (did_pop) void'(mq.pop_front());
            if (m_dq != m_last) begin
                m_last = m_dq;
                if (mq.size() < DEPTH) begin
                    mq.push_back(m_dq);
                    sb.push_back(m_dq);
                end else begin
                    dropped = 1;
                end
            end
            if (dropped) begin
                m_ovf = 1;
                if (ovf_clr) m_cnt = 1;
                else if (m_cnt < 255) m_cnt = m_cnt + 1;
            end else if (ovf_clr) begin
                m_ovf = 0;
                m_cnt = 0;
            end
            m_dq = din;
        end
    end

    // Monitor: compare status every cycle and consume the scoreboard on each handshake.
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
            chk("level", int'(level), mq.size());
            chk("ovf", int'(ovf), int'(m_ovf));
            chk("ovf_cnt", int'(ovf_cnt), m_cnt);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underrun", 1, 0);
                end else begin
                    chk("out_data", int'(out_data), int'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; din = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        step(1);
        started = 1;
        step(1);

        // idle after reset
        rst_n = 1'b1;
        step(20);
        chk("t1_valid", int'(out_valid), 0);
        chk("t1_data", int'(out_data), 0);

        // single word with consumer ready
        out_ready = 1'b1;
        din = 8'h5A;
        step(2);
        chk("t2_valid", int'(out_valid), 1);
        chk("t2_data", int'(out_data), 8'h5A);
        step(1);
        chk("t2_level", int'(level), 0);

        // fill with stalled consumer, then overflow once
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            din = 8'(v);
            step(3);
        end
        chk("t3_level", int'(level), 4);
        chk("t3_ovf", int'(ovf), 1);
        chk("t3_cnt", int'(ovf_cnt), 1);
        out_ready = 1'b1;
        step(5);
        out_ready = 1'b0;
        chk("t3_drained", int'(level), 0);

        // push into a full FIFO on the same edge as a pop
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        for (int v = 8'h11; v <= 8'h14; v++) begin
            din = 8'(v);
            step(3);
        end
        din = 8'h15;
        step(1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("t4_level", int'(level), 4);
        chk("t4_ovf", int'(ovf), 0);
        out_ready = 1'b1;
        step(5);
        out_ready = 1'b0;

        // counter saturation, then clear colliding with an overflow
        for (int i = 0; i < 300; i++) begin
            din = (i % 2 == 0) ? 8'hA0 : 8'hA1;
            step(1);
        end
        chk("t5_sat", int'(ovf_cnt), 255);
        ovf_clr = 1'b1;
        din = 8'hA2;
        step(1);
        ovf_clr = 1'b0;
        chk("t5_clr_ovf", int'(ovf), 1);
        chk("t5_clr_cnt", int'(ovf_cnt), 1);
        step(2);
        out_ready = 1'b1;
        step(6);
        out_ready = 1'b0;

        // reset mid-operation with a pending non-reset word on the bus
        for (int v = 8'h31; v <= 8'h33; v++) begin
            din = 8'(v);
            step(3);
        end
        chk("t6_level3", int'(level), 3);
        din = 8'h77;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("t6_level", int'(level), 0);
        chk("t6_valid", int'(out_valid), 0);
        step(1);
        chk("t6_not_yet", int'(out_valid), 0);
        step(1);
        chk("t6_valid2", int'(out_valid), 1);
        chk("t6_data", int'(out_data), 8'h77);
        out_ready = 1'b1;
        step(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) din = 8'($urandom);
            out_ready = ((i / 200) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(4) == 0);
            ovf_clr   = ($urandom_range(49) == 0);
            rst_n     = ($urandom_range(499) != 0);
            step(1);
        end
        rst_n = 1'b1;
        ovf_clr = 1'b0;
        out_ready = 1'b1;
        step(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
